// File: rtl/img_row_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// img_row_fetch_ctrl
//
// Sits between the scaler's row-request FIFO and the DDR read port. Each
// accepted request (a source row number) becomes BEATS_PER_ROW/BURST_LEN
// fixed-length read bursts. The returned beats are written into an 8-slot line
// space at {slot, beat}. row_done pulses with the last write of each row.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   frame_start       1-cycle pulse: abort the current row, resample base_addr,
//                     restart slot numbering at 0
//   base_addr         frame base byte address
//   req_rdy/req_vld   row request handshake, req_h = source row number
//   cmd_vld/cmd_rdy   DDR read command handshake
//   cmd_addr/cmd_len  burst start byte address / constant BURST_LEN-1
//   rd_data_vld       DDR read beat valid (no backpressure), rd_data = beat
//   buf_wr_en         line-space write strobe, one cycle after the beat
//   buf_wr_addr       {slot[2:0], beat[6:0]}
//   buf_wr_data       registered copy of rd_data
//   row_done          pulse with the last write of a row, row_done_id = slot
//   busy              not idle, or beats of an aborted row still draining
//   err_unexp         sticky: a beat arrived with nothing outstanding
// -----------------------------------------------------------------------------
module img_row_fetch_ctrl #(
  parameter int ADDR_W        = 28,
  parameter int ROW_BYTES     = 1280,
  parameter int BEAT_BYTES    = 16,
  parameter int BURST_LEN     = 16,
  parameter int BEATS_PER_ROW = 80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              req_rdy,
  input  logic              req_vld,
  input  logic [8:0]        req_h,
  output logic              cmd_vld,
  input  logic              cmd_rdy,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  input  logic              rd_data_vld,
  input  logic [127:0]      rd_data,
  output logic              buf_wr_en,
  output logic [9:0]        buf_wr_addr,
  output logic [127:0]      buf_wr_data,
  output logic              row_done,
  output logic [2:0]        row_done_id,
  output logic              busy,
  output logic              err_unexp
);

  localparam int BURSTS      = BEATS_PER_ROW / BURST_LEN;
  localparam int BIDX_W      = $clog2(BURSTS + 1);
  localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;

  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_reg;
  logic [BIDX_W-1:0] burst_idx;
  logic [6:0]        beat_cnt;
  logic [7:0]        outstanding;
  logic [7:0]        drain_cnt;
  logic [2:0]        slot;

  logic        cmd_acc;
  logic        req_acc;
  logic        beat_drain;
  logic        beat_take;
  logic        beat_unexp;
  logic        row_last;
  logic [19:0] row_off;
  logic [7:0]  drain_nxt;

  assign cmd_len = 8'(BURST_LEN - 1);
  assign busy    = (state != IDLE) || (drain_cnt != 8'd0);

  // req_rdy is only ever high in IDLE with nothing left to drain.
  assign cmd_acc    = cmd_vld & cmd_rdy;
  assign req_acc    = req_vld & req_rdy & ~frame_start;
  assign beat_drain = rd_data_vld & (drain_cnt != 8'd0);
  assign beat_take  = rd_data_vld & (drain_cnt == 8'd0) & (outstanding != 8'd0);
  assign beat_unexp = rd_data_vld & (drain_cnt == 8'd0) & (outstanding == 8'd0);
  assign row_last   = beat_take & (beat_cnt == 7'(BEATS_PER_ROW - 1));

  // Constant multiply; 511*1280 still fits in 20 bits.
  assign row_off = 20'(req_h) * 20'(ROW_BYTES);

  // On an abort every beat still owed by DDR has to be swallowed: whatever was
  // outstanding, plus a burst whose command handshake completes in the same
  // cycle, minus a beat consumed right now.
  always_comb begin
    // NOTE: assign a default first so every path drives drain_nxt and no latch is inferred.
    drain_nxt = drain_cnt - {7'd0, beat_drain};
    if (frame_start) begin
      drain_nxt = drain_cnt + outstanding + (cmd_acc ? 8'(BURST_LEN) : 8'd0)
                - {7'd0, beat_drain | beat_take};
    end
  end

  // NOTE: all state and registered outputs update with non-blocking assignments so every
  // read in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base_reg    <= '0;
      burst_idx   <= '0;
      beat_cnt    <= '0;
      outstanding <= '0;
      drain_cnt   <= '0;
      slot        <= '0;
      req_rdy     <= 1'b0;
      cmd_vld     <= 1'b0;
      cmd_addr    <= '0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
      row_done    <= 1'b0;
      row_done_id <= '0;
      err_unexp   <= 1'b0;
    end else begin
      buf_wr_en <= 1'b0;
      row_done  <= 1'b0;
      drain_cnt <= drain_nxt;
      if (beat_unexp) err_unexp <= 1'b1;

      if (frame_start) begin
        base_reg    <= base_addr;
        slot        <= '0;
        beat_cnt    <= '0;
        burst_idx   <= '0;
        outstanding <= '0;
        state       <= IDLE;
        cmd_vld     <= 1'b0;
        req_rdy     <= 1'b0;
      end else begin
        outstanding <= outstanding + (cmd_acc ? 8'(BURST_LEN) : 8'd0) - {7'd0, beat_take};

        if (beat_take) begin
          buf_wr_en   <= 1'b1;
          buf_wr_addr <= {slot, beat_cnt};
          buf_wr_data <= rd_data;
          beat_cnt    <= beat_cnt + 7'd1;
          if (row_last) begin
            row_done    <= 1'b1;
            row_done_id <= slot;
            slot        <= slot + 3'd1;
            beat_cnt    <= '0;
          end
        end

        case (state)
          IDLE: begin
            // Registered: after row_done the first accept lands one cycle later.
            req_rdy <= !req_acc && (drain_nxt == 8'd0);
            if (req_acc) begin
              state     <= CMD;
              cmd_vld   <= 1'b1;
              cmd_addr  <= base_reg + ADDR_W'(row_off);
              burst_idx <= '0;
              beat_cnt  <= '0;
            end
          end
          CMD: begin
            if (cmd_acc) begin
              burst_idx <= burst_idx + 1'b1;
              cmd_addr  <= cmd_addr + ADDR_W'(BURST_BYTES);
              if (burst_idx == BIDX_W'(BURSTS - 1)) begin
                cmd_vld <= 1'b0;
                state   <= WAIT;
              end
            end
          end
          WAIT: begin
            if (row_last) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_img_row_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for img_row_fetch_ctrl. A DDR responder owes 16 beats per accepted
// command and returns them with random spacing. Expected commands are queued
// when a request is accepted; expected writes are queued as beats are sent,
// tagged with the slot/beat a row-level model assigns. A negedge monitor pops
// and compares whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_img_row_fetch_ctrl;

  typedef struct {
    logic [9:0]   addr;
    logic [127:0] data;
    bit           last;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst_n, frame_start, req_vld, cmd_rdy, rd_data_vld;
  logic [27:0]  base_addr;
  logic [8:0]   req_h;
  logic [127:0] rd_data;
  logic         req_rdy, cmd_vld, buf_wr_en, row_done, busy, err_unexp;
  logic [27:0]  cmd_addr;
  logic [7:0]   cmd_len;
  logic [9:0]   buf_wr_addr;
  logic [127:0] buf_wr_data;
  logic [2:0]   row_done_id;

  // Model / stimulus control
  int          n_checks = 0, n_fail = 0;
  int          pending = 0, model_drain = 0, exp_slot = 0, exp_beat = 0;
  int          beats_sent = 0, cmd_acc_cnt = 0, done_cnt = 0, rows_exp = 0;
  int          cmd_mode = 0, beat_pct = 100, cyc = 0;
  bit          beat_en = 0, inject = 0, in_row = 0, rd_prev = 0;
  logic [27:0] base_m = '0;
  logic [27:0] cmd_q[$];
  wr_t         wr_q[$];

  img_row_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .base_addr(base_addr),
    .req_rdy(req_rdy), .req_vld(req_vld), .req_h(req_h),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rd_data_vld(rd_data_vld), .rd_data(rd_data),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .row_done(row_done), .row_done_id(row_done_id), .busy(busy), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [191:0] outs();
    return 192'({req_rdy, cmd_vld, cmd_addr, buf_wr_en, buf_wr_addr, buf_wr_data,
                 row_done, row_done_id, busy, err_unexp});
  endfunction

  // DDR responder: command ready pattern and beat return.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (cmd_mode)
        0:       cmd_rdy = 1'b0;
        1:       cmd_rdy = 1'b1;
        2:       cmd_rdy = (cyc % 3 == 0);
        default: cmd_rdy = 1'($urandom_range(0, 1));
      endcase
      rd_data_vld = 1'b0;
      if (inject) begin
        rd_data_vld = 1'b1;
        rd_data     = {$urandom, $urandom, $urandom, $urandom};
        inject      = 0;
      end else if (beat_en && pending > 0 && $urandom_range(0, 99) < beat_pct) begin
        wr_t w;
        rd_data_vld = 1'b1;
        rd_data     = {$urandom, $urandom, $urandom, $urandom};
        pending--;
        beats_sent++;
        if (model_drain > 0) begin
          model_drain--;
        end else begin
          w.addr = {3'(exp_slot), 7'(exp_beat)};
          w.data = rd_data;
          w.last = (exp_beat == 79);
          wr_q.push_back(w);
          exp_beat++;
          if (exp_beat == 80) begin
            exp_beat = 0;
            exp_slot = (exp_slot + 1) % 8;
          end
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    wr_t         w;
    logic [27:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rd_prev) begin
          check("req_rdy_after_row_done", 192'(req_rdy), 192'(1));
          rd_prev = 0;
        end
        if (in_row) check("req_rdy_during_row", 192'(req_rdy), 192'(0));
        if (cmd_vld && cmd_rdy) begin
          cmd_acc_cnt++;
          check("cmd_len", 192'(cmd_len), 192'(15));
          if (cmd_q.size() == 0) begin
            check("unexpected_cmd", 192'(cmd_vld), 192'(0));
          end else begin
            e = cmd_q.pop_front();
            check("cmd_addr", 192'(cmd_addr), 192'(e));
          end
          pending += 16;
        end
        if (buf_wr_en) begin
          if (wr_q.size() == 0) begin
            check("unexpected_write", 192'(buf_wr_en), 192'(0));
          end else begin
            w = wr_q.pop_front();
            check("wr_addr", 192'(buf_wr_addr), 192'(w.addr));
            check("wr_data", 192'(buf_wr_data), 192'(w.data));
            check("row_done_on_last", 192'(row_done), 192'(w.last));
            if (w.last && row_done) check("row_done_id", 192'(row_done_id), 192'(w.addr[9:7]));
          end
        end else if (row_done) begin
          check("row_done_without_write", 192'(row_done), 192'(0));
        end
        if (row_done) begin
          done_cnt++;
          in_row  = 0;
          rd_prev = 1;
        end
      end
    end
  end

  task automatic do_req(input logic [8:0] h);
    bit ok = 0;
    @(posedge clk);
    #1 req_vld = 1'b1;
    req_h = h;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (req_rdy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("req_accept_timeout", 192'(req_rdy), 192'(1));
    end else begin
      for (int i = 0; i < 5; i++) cmd_q.push_back(base_m + 28'(h) * 28'd1280 + 28'(i * 256));
      rows_exp++;
    end
    @(posedge clk);
    #1 req_vld = 1'b0;
    in_row = ok;
  endtask

  task automatic do_frame_start(input logic [27:0] b);
    @(posedge clk);
    #1 frame_start = 1'b1;
    base_addr   = b;
    base_m      = b;
    model_drain = pending;
    exp_slot    = 0;
    exp_beat    = 0;
    cmd_q.delete();
    if (in_row) rows_exp--;
    in_row  = 0;
    rd_prev = 0;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic model_reset();
    beat_en = 0; cmd_mode = 0; pending = 0; model_drain = 0;
    exp_slot = 0; exp_beat = 0; base_m = '0;
    cmd_q.delete();
    wr_q.delete();
    if (in_row) rows_exp--;
    in_row = 0; rd_prev = 0;
  endtask

  task automatic wait_quiet();
    bit q = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      if (pending == 0 && wr_q.size() == 0 && cmd_q.size() == 0 && !in_row) begin
        q = 1;
        break;
      end
    end
    check("rows_completed_in_time", 192'(q), 192'(1));
    check("row_done_count", 192'(done_cnt), 192'(rows_exp));
    @(negedge clk);
    check("busy_when_idle", 192'(busy), 192'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b0, c0, p;
    rst_n = 1'b0; frame_start = 1'b0; req_vld = 1'b0; req_h = '0;
    base_addr = '0; cmd_rdy = 1'b0; rd_data_vld = 1'b0; rd_data = '0;

    // Reset values
    #1;
    check("reset_outputs", outs(), 192'(0));
    check("reset_cmd_len", 192'(cmd_len), 192'(15));
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("req_rdy_after_reset", 192'(req_rdy), 192'(1));

    // Directed row: base 0x100000, row 3, cmd_rdy high
    cmd_mode = 1; beat_en = 1; beat_pct = 100;
    do_frame_start(28'h100000);
    do_req(9'd3);
    wait_quiet();

    // Nine back-to-back requests: slot ids 0..7 then 0
    do_frame_start(28'($urandom));
    cmd_mode = 3; beat_pct = 60;
    for (int i = 0; i < 9; i++) do_req(9'($urandom_range(0, 511)));
    wait_quiet();

    // cmd_rdy 1-of-3 with beats interleaved with command accepts
    cmd_mode = 2; beat_pct = 50;
    for (int i = 0; i < 2; i++) do_req(9'($urandom_range(0, 479)));
    wait_quiet();
    check("no_err_in_normal_traffic", 192'(err_unexp), 192'(0));

    // Abort after 2 commands and 10 beats: 22 beats must drain silently
    cmd_mode = 1; beat_pct = 100;
    c0 = cmd_acc_cnt; b0 = beats_sent;
    do_req(9'd100);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (cmd_acc_cnt - c0 >= 2) cmd_mode = 0;
      if (beats_sent - b0 >= 10) beat_en = 0;
      if (cmd_mode == 0 && !beat_en) break;
    end
    repeat (2) @(posedge clk);
    do_frame_start(28'h0234000);
    @(negedge clk);
    check("busy_while_draining", 192'(busy), 192'(1));
    check("req_rdy_while_draining", 192'(req_rdy), 192'(0));
    beat_en = 1; beat_pct = 70;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      p = pending;
      #2;
      if (p > 0) begin
        check("req_rdy_low_in_drain", 192'(req_rdy), 192'(0));
      end else begin
        check("req_rdy_after_drain", 192'(req_rdy), 192'(1));
        break;
      end
    end
    cmd_mode = 1;
    do_req(9'd7);
    wait_quiet();

    // Unexpected beat while idle
    check("err_clear_before", 192'(err_unexp), 192'(0));
    @(posedge clk);
    inject = 1;
    @(posedge clk);
    #2;
    check("err_set", 192'(err_unexp), 192'(1));
    repeat (5) @(posedge clk);
    #2;
    check("err_sticky", 192'(err_unexp), 192'(1));
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("err_async_clear", 192'(err_unexp), 192'(0));
    check("reset_outputs_2", outs(), 192'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Reset in the middle of a row, then a fresh row from slot 0 / burst 0
    cmd_mode = 2; beat_en = 1; beat_pct = 100;
    b0 = beats_sent;
    do_req(9'd50);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (beats_sent - b0 >= 40) break;
    end
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_mid_row_outputs", outs(), 192'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    cmd_mode = 1; beat_en = 1; beat_pct = 80;
    do_req(9'd479);
    wait_quiet();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
